imem_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the single-cycle/pipelined core. It owns the program counter, drives the word address of the asynchronous-read instruction memory, and registers each fetched word into a valid/ready output stage toward decode. It also accepts branch redirects from execute, and halts when the PC leaves the populated memory range.

---
 rtl/imem_fetch_ctrl_pkg.sv | 15 +
 rtl/imem_fetch_ctrl_if.sv | 31 +++
 rtl/imem_fetch_ctrl_fetch_out_stage.sv | 34 +++
 rtl/imem_fetch_ctrl.sv | 126 ++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
// Carries the FSM state encoding and the default bus/memory dimensions.
package imem_fetch_ctrl_pkg;

    localparam int DEF_BITSIZE = 32;
    localparam int DEF_REGSIZE = 32;
    localparam int DEF_DEPTH   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side bundle: instruction memory port, decode valid/ready stage, branch redirect, status.
// master = fetch controller, slave = its environment (memory, decode, execute).
interface imem_fetch_ctrl_if
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int BITSIZE = DEF_BITSIZE,
    parameter int REGSIZE = DEF_REGSIZE
);
    logic               start;
    logic [REGSIZE-1:0] imem_addr;
    logic [BITSIZE-1:0] imem_data;
    logic               if_valid;
    logic               if_ready;
    logic [BITSIZE-1:0] if_instr;
    logic [REGSIZE-1:0] if_pc;
    logic               br_valid;
    logic [REGSIZE-1:0] br_pc;
    logic [REGSIZE-1:0] br_offset;
    logic               halted;
    logic [15:0]        fetch_count;

    modport master (
        input  start, imem_data, if_ready, br_valid, br_pc, br_offset,
        output imem_addr, if_valid, if_instr, if_pc, halted, fetch_count
    );

    modport slave (
        output start, imem_data, if_ready, br_valid, br_pc, br_offset,
        input  imem_addr, if_valid, if_instr, if_pc, halted, fetch_count
    );
endinterface

// File: rtl/imem_fetch_ctrl_fetch_out_stage.sv
// Output register toward decode: one cycle from memory word to if_instr/if_pc.
// Holds contents while not captured; drop clears valid but keeps the last instr/pc visible.
module fetch_out_stage
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int BITSIZE = DEF_BITSIZE,
    parameter int REGSIZE = DEF_REGSIZE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               capture,
    input  logic               drop,
    input  logic [BITSIZE-1:0] next_instr,
    input  logic [REGSIZE-1:0] next_pc,
    output logic               valid,
    output logic [BITSIZE-1:0] instr,
    output logic [REGSIZE-1:0] pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (drop) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
            instr <= next_instr;
            pc    <= next_pc;
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: PC, async-read imem addressing, redirects; 1-cycle fetch latency.
// Stalls (PC and output held) while decode withholds if_ready on a valid word.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int BITSIZE = DEF_BITSIZE,
    parameter int REGSIZE = DEF_REGSIZE,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    imem_fetch_ctrl_if.master bus
);

    localparam logic [REGSIZE-1:0] DEPTH_W = REGSIZE'(DEPTH);

    state_t             state;
    state_t             state_nxt;
    logic [REGSIZE-1:0] pc;
    logic [REGSIZE-1:0] pc_nxt;
    logic [REGSIZE-1:0] target;
    logic               pc_upd;
    logic               load;
    logic               pc_ok;
    logic               tgt_ok;
    logic               capture;
    logic               drop;
    logic               xfer;

    // Unsigned compare: negative offsets that wrap past zero land out of range.
    assign target = bus.br_pc + bus.br_offset;
    assign tgt_ok = (target < DEPTH_W);
    assign pc_ok  = (pc < DEPTH_W);
    assign load   = !bus.if_valid || bus.if_ready;
    assign xfer   = bus.if_valid && bus.if_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (bus.br_valid) begin
                    if (!tgt_ok) begin
                        state_nxt = ST_HALT;
                    end
                end else if (load && !pc_ok) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Redirect wins over the normal load; the word in the stage is flushed either way.
    always_comb begin
        capture = 1'b0;
        drop    = 1'b0;
        pc_upd  = 1'b0;
        pc_nxt  = pc;
        if (state == ST_FETCH) begin
            if (bus.br_valid) begin
                drop = 1'b1;
                if (tgt_ok) begin
                    pc_upd = 1'b1;
                    pc_nxt = target;
                end
            end else if (load) begin
                if (pc_ok) begin
                    capture = 1'b1;
                    pc_upd  = 1'b1;
                    pc_nxt  = pc + REGSIZE'(1);
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
        end else if (pc_upd) begin
            pc <= pc_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.fetch_count <= '0;
        end else if (state == ST_FETCH && xfer) begin
            bus.fetch_count <= bus.fetch_count + 16'd1;
        end
    end

    assign bus.imem_addr = pc;
    assign bus.halted    = (state == ST_HALT);

    fetch_out_stage #(
        .BITSIZE(BITSIZE),
        .REGSIZE(REGSIZE)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .capture   (capture),
        .drop      (drop),
        .next_instr(bus.imem_data),
        .next_pc   (pc),
        .valid     (bus.if_valid),
        .instr     (bus.if_instr),
        .pc        (bus.if_pc)
    );

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus a transfer scoreboard fed by the scenarios.
module tb_imem_fetch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_pc = 32'd0;

    always #5 clk = ~clk;

    imem_fetch_ctrl_if #(.BITSIZE(32), .REGSIZE(32)) bus ();

    imem_fetch_ctrl #(.BITSIZE(32), .REGSIZE(32), .DEPTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'hF280_0022;
        return 32'h1357_0000 | (a * 32'h0000_0101);
    endfunction

    assign bus.imem_data = (bus.imem_addr < 32'd32) ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;

    // Scoreboard: every accepted word must be the next expected PC with its memory contents.
    always @(negedge clk) begin
        if (!rst && bus.if_valid && bus.if_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected got_pc=%0d want=none", bus.if_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (bus.if_pc !== e || bus.if_instr !== mem_word(e)) begin
                    bad++;
                    $display("FAIL sb_xfer got_pc=%0d got_instr=%08h want_pc=%0d want_instr=%08h",
                             bus.if_pc, bus.if_instr, e, mem_word(e));
                end
            end
            last_pc = bus.if_pc;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bus.start = 1'b0; bus.if_ready = 1'b0; bus.br_valid = 1'b0;
        bus.br_pc = 32'd0; bus.br_offset = 32'd0;
        rst = 1'b1;
        #2;
        total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h want=0", bus.if_valid); end
        total++; if (bus.if_instr !== 32'd0) begin bad++; $display("FAIL reset_instr got=%08h want=0", bus.if_instr); end
        total++; if (bus.if_pc !== 32'd0) begin bad++; $display("FAIL reset_pc got=%0d want=0", bus.if_pc); end
        total++; if (bus.imem_addr !== 32'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", bus.imem_addr); end
        total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%0h want=0", bus.halted); end
        total++; if (bus.fetch_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.fetch_count); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_start_stream;
        bus.if_ready = 1'b1;
        for (int p = 0; p <= 5; p++) exp_q.push_back(32'(p));
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL start_first_cycle_valid got=%0h want=0", bus.if_valid); end
        for (int p = 0; p <= 4; p++) begin
            tick();
            total++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(p) || bus.if_instr !== mem_word(32'(p))) begin
                bad++;
                $display("FAIL stream_word valid=%0h pc=%0d instr=%08h want pc=%0d instr=%08h",
                         bus.if_valid, bus.if_pc, bus.if_instr, p, mem_word(32'(p)));
            end
        end
        total++; if (bus.fetch_count !== 16'd4) begin bad++; $display("FAIL stream_count got=%0d want=4", bus.fetch_count); end
    endtask

    task automatic test_backpressure;
        bus.if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'd4 || bus.imem_addr !== 32'd5 || bus.fetch_count !== 16'd4) begin
                bad++;
                $display("FAIL stall_hold valid=%0h pc=%0d addr=%0d count=%0d want 1/4/5/4",
                         bus.if_valid, bus.if_pc, bus.imem_addr, bus.fetch_count);
            end
        end
        bus.if_ready = 1'b1;
        for (int p = 5; p <= 6; p++) begin
            tick();
            total++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(p) || bus.fetch_count !== 16'(p)) begin
                bad++;
                $display("FAIL stall_release valid=%0h pc=%0d count=%0d want pc=%0d count=%0d",
                         bus.if_valid, bus.if_pc, bus.fetch_count, p, p);
            end
        end
    endtask

    task automatic test_branch;
        for (int p = 6; p <= 9; p++) exp_q.push_back(32'(p));
        exp_q.push_back(32'd11);
        for (int p = 7; p <= 9; p++) begin
            tick();
            total++; if (bus.if_pc !== 32'(p)) begin bad++; $display("FAIL branch_pre pc got=%0d want=%0d", bus.if_pc, p); end
        end
        bus.br_valid = 1'b1; bus.br_pc = 32'd9; bus.br_offset = 32'd2;
        tick();
        bus.br_valid = 1'b0;
        total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL branch_bubble valid got=%0h want=0", bus.if_valid); end
        total++; if (bus.imem_addr !== 32'd11) begin bad++; $display("FAIL branch_addr got=%0d want=11", bus.imem_addr); end
        total++; if (bus.fetch_count !== 16'd10) begin bad++; $display("FAIL branch_count got=%0d want=10", bus.fetch_count); end
        tick();
        total++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'd11 || bus.if_instr !== mem_word(32'd11)) begin
            bad++;
            $display("FAIL branch_target valid=%0h pc=%0d instr=%08h want pc=11", bus.if_valid, bus.if_pc, bus.if_instr);
        end
    endtask

    task automatic test_oob_redirect;
        exp_q.push_back(32'd12);
        exp_q.push_back(32'd13);
        tick();
        tick();
        total++; if (bus.if_pc !== 32'd13) begin bad++; $display("FAIL oob_pre pc got=%0d want=13", bus.if_pc); end
        bus.br_valid = 1'b1; bus.br_pc = 32'd13; bus.br_offset = 32'hFFFF_FFEC;
        tick();
        bus.br_valid = 1'b0;
        total++; if (bus.halted !== 1'b1) begin bad++; $display("FAIL oob_halted got=%0h want=1", bus.halted); end
        total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL oob_valid got=%0h want=0", bus.if_valid); end
        total++; if (bus.fetch_count !== 16'd13) begin bad++; $display("FAIL oob_count got=%0d want=13", bus.fetch_count); end
        bus.start = 1'b1; bus.br_valid = 1'b1; bus.br_pc = 32'd0; bus.br_offset = 32'd3;
        tick();
        bus.start = 1'b0; bus.br_valid = 1'b0;
        tick();
        tick();
        total++;
        if (bus.halted !== 1'b1 || bus.if_valid !== 1'b0 || bus.fetch_count !== 16'd13) begin
            bad++;
            $display("FAIL halt_ignores halted=%0h valid=%0h count=%0d want 1/0/13", bus.halted, bus.if_valid, bus.fetch_count);
        end
        total++;
        if (bus.if_pc !== 32'd13 || bus.if_instr !== mem_word(32'd13)) begin
            bad++;
            $display("FAIL halt_hold pc=%0d instr=%08h want pc=13 instr=%08h", bus.if_pc, bus.if_instr, mem_word(32'd13));
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL oob_sb_left got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_run_to_end;
        int n;
        tick();
        #2 rst = 1'b1;
        #1;
        total++;
        if (bus.halted !== 1'b0 || bus.fetch_count !== 16'd0 || bus.if_pc !== 32'd0) begin
            bad++;
            $display("FAIL end_reset halted=%0h count=%0d pc=%0d want 0/0/0", bus.halted, bus.fetch_count, bus.if_pc);
        end
        #3 rst = 1'b0;
        exp_q.delete();
        for (int p = 0; p < 32; p++) exp_q.push_back(32'(p));
        bus.if_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (bus.halted !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        total++; if (bus.halted !== 1'b1) begin bad++; $display("FAIL end_timeout halted=%0h want=1", bus.halted); end
        total++; if (bus.fetch_count !== 16'd32) begin bad++; $display("FAIL end_count got=%0d want=32", bus.fetch_count); end
        total++; if (last_pc !== 32'd31) begin bad++; $display("FAIL end_last_pc got=%0d want=31", last_pc); end
        total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL end_valid got=%0h want=0", bus.if_valid); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL end_sb_left got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_async_reset;
        tick();
        #2 rst = 1'b1;
        #5 rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        bus.if_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        bus.if_ready = 1'b0;
        tick();
        total++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'd2 || bus.fetch_count !== 16'd2) begin
            bad++;
            $display("FAIL ar_pre valid=%0h pc=%0d count=%0d want 1/2/2", bus.if_valid, bus.if_pc, bus.fetch_count);
        end
        #2 rst = 1'b1;
        #1;
        total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%0h want=0", bus.if_valid); end
        total++; if (bus.if_instr !== 32'd0 || bus.if_pc !== 32'd0) begin bad++; $display("FAIL ar_out instr=%08h pc=%0d want 0/0", bus.if_instr, bus.if_pc); end
        total++; if (bus.imem_addr !== 32'd0) begin bad++; $display("FAIL ar_addr got=%0d want=0", bus.imem_addr); end
        total++; if (bus.fetch_count !== 16'd0 || bus.halted !== 1'b0) begin bad++; $display("FAIL ar_status count=%0d halted=%0h want 0/0", bus.fetch_count, bus.halted); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL ar_sb_left got=%0d want=0", exp_q.size()); end
        #3 rst = 1'b0;
        exp_q.push_back(32'd0);
        bus.if_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        total++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'd0 || bus.if_instr !== 32'hF280_0022) begin
            bad++;
            $display("FAIL ar_restart valid=%0h pc=%0d instr=%08h want 1/0/f2800022", bus.if_valid, bus.if_pc, bus.if_instr);
        end
        tick();
        bus.if_ready = 1'b0;
        total++; if (bus.if_pc !== 32'd1) begin bad++; $display("FAIL ar_next pc got=%0d want=1", bus.if_pc); end
        tick();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL ar_sb_final got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_start_stream();
        test_backpressure();
        test_branch();
        test_oob_redirect();
        test_run_to_end();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
